// File: rtl/ysyx_22050078_mem_arbiter.sv
// ============================================================================
// Module  : ysyx_22050078_mem_arbiter
// Brief   : Round-robin arbiter sharing one memory port between IFU and LSU,
//           one outstanding transaction, response routed to the owner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050078_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // IFU side
    input  logic              i_ifu_req_valid,
    output logic              o_ifu_req_ready,
    input  logic [ADDR_W-1:0] i_ifu_addr,
    output logic              o_ifu_resp_valid,
    output logic [DATA_W-1:0] o_ifu_rdata,
    // LSU side
    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready,
    input  logic              i_lsu_wen,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [MASK_W-1:0] i_lsu_wmask,
    output logic              o_lsu_resp_valid,
    output logic [DATA_W-1:0] o_lsu_rdata,
    // memory side
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [MASK_W-1:0] o_mem_wmask,
    input  logic              i_mem_resp_valid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IFU  = 2'd1;
    localparam logic [1:0] OWN_LSU  = 2'd2;

    localparam logic       GNT_IFU  = 1'b0;
    localparam logic       GNT_LSU  = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        r_owner;
    logic              r_last_grant;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_ifu_resp_valid;
    logic [DATA_W-1:0] r_ifu_rdata;
    logic              r_lsu_resp_valid;
    logic [DATA_W-1:0] r_lsu_rdata;

    logic w_idle;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_capture;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_grant_ifu = w_idle && i_ifu_req_valid &&
                      (!i_lsu_req_valid || (r_last_grant == GNT_LSU));
        w_grant_lsu = w_idle && i_lsu_req_valid &&
                      (!i_ifu_req_valid || (r_last_grant == GNT_IFU));
        w_capture   = ((r_state == S_REQ) && i_mem_req_ready && i_mem_resp_valid) ||
                      ((r_state == S_RESP) && i_mem_resp_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_NONE;
            r_last_grant <= GNT_IFU;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ifu) begin
                        r_state      <= S_REQ;
                        r_owner      <= OWN_IFU;
                        r_last_grant <= GNT_IFU;
                        r_wen        <= 1'b0;
                        r_addr       <= i_ifu_addr;
                        r_wdata      <= '0;
                        r_wmask      <= '0;
                    end else if (w_grant_lsu) begin
                        r_state      <= S_REQ;
                        r_owner      <= OWN_LSU;
                        r_last_grant <= GNT_LSU;
                        r_wen        <= i_lsu_wen;
                        r_addr       <= i_lsu_addr;
                        r_wdata      <= i_lsu_wdata;
                        r_wmask      <= i_lsu_wmask;
                    end
                end
                S_REQ: begin
                    if (i_mem_req_ready) begin
                        if (i_mem_resp_valid) begin
                            r_state <= S_IDLE;
                            r_owner <= OWN_NONE;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (i_mem_resp_valid) begin
                        r_state <= S_IDLE;
                        r_owner <= OWN_NONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Response pulses are registered, so they appear the cycle after capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifu_resp_valid <= 1'b0;
            r_ifu_rdata      <= '0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_rdata      <= '0;
        end else begin
            r_ifu_resp_valid <= w_capture && (r_owner == OWN_IFU);
            r_lsu_resp_valid <= w_capture && (r_owner == OWN_LSU);
            if (w_capture && (r_owner == OWN_IFU)) begin
                r_ifu_rdata <= i_mem_rdata;
            end
            if (w_capture && (r_owner == OWN_LSU)) begin
                r_lsu_rdata <= r_wen ? '0 : i_mem_rdata;
            end
        end
    end

    assign o_ifu_req_ready  = w_grant_ifu;
    assign o_lsu_req_ready  = w_grant_lsu;
    assign o_ifu_resp_valid = r_ifu_resp_valid;
    assign o_ifu_rdata      = r_ifu_rdata;
    assign o_lsu_resp_valid = r_lsu_resp_valid;
    assign o_lsu_rdata      = r_lsu_rdata;
    assign o_mem_req_valid  = (r_state == S_REQ);
    assign o_mem_wen        = r_wen;
    assign o_mem_addr       = r_addr;
    assign o_mem_wdata      = r_wdata;
    assign o_mem_wmask      = r_wmask;

`ifndef SYNTHESIS
    a_ifu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (i_ifu_req_valid && !o_ifu_req_ready) |=> i_ifu_req_valid);
    a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (i_lsu_req_valid && !o_lsu_req_ready) |=> i_lsu_req_valid);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050078_mem_arbiter.sv
// ============================================================================
// Module  : tb_ysyx_22050078_mem_arbiter
// Brief   : Directed self-checking bench for the IFU/LSU memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22050078_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_ifu_req_valid;
    logic        o_ifu_req_ready;
    logic [63:0] i_ifu_addr;
    logic        o_ifu_resp_valid;
    logic [63:0] o_ifu_rdata;
    logic        i_lsu_req_valid;
    logic        o_lsu_req_ready;
    logic        i_lsu_wen;
    logic [63:0] i_lsu_addr;
    logic [63:0] i_lsu_wdata;
    logic [7:0]  i_lsu_wmask;
    logic        o_lsu_resp_valid;
    logic [63:0] o_lsu_rdata;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic        o_mem_wen;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_resp_valid;
    logic [63:0] i_mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ysyx_22050078_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MASK_W(8)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_ifu_req_valid  (i_ifu_req_valid),
        .o_ifu_req_ready  (o_ifu_req_ready),
        .i_ifu_addr       (i_ifu_addr),
        .o_ifu_resp_valid (o_ifu_resp_valid),
        .o_ifu_rdata      (o_ifu_rdata),
        .i_lsu_req_valid  (i_lsu_req_valid),
        .o_lsu_req_ready  (o_lsu_req_ready),
        .i_lsu_wen        (i_lsu_wen),
        .i_lsu_addr       (i_lsu_addr),
        .i_lsu_wdata      (i_lsu_wdata),
        .i_lsu_wmask      (i_lsu_wmask),
        .o_lsu_resp_valid (o_lsu_resp_valid),
        .o_lsu_rdata      (o_lsu_rdata),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_wen        (o_mem_wen),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_wmask      (o_mem_wmask),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_rdata      (i_mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_ifu_req_valid  = 1'b0;
        i_ifu_addr       = '0;
        i_lsu_req_valid  = 1'b0;
        i_lsu_wen        = 1'b0;
        i_lsu_addr       = '0;
        i_lsu_wdata      = '0;
        i_lsu_wmask      = '0;
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_rdata      = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits (bounded) for a memory request, then answers it combinationally.
    task automatic serve(input logic [63:0] rd);
        int n;
        n = 0;
        while (!o_mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("serve_req", 64'(o_mem_req_valid), 64'd1);
        i_mem_req_ready  = 1'b1;
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = rd;
        tick();
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_rdata      = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({o_ifu_req_ready, o_lsu_req_ready, o_mem_req_valid,
                                o_ifu_resp_valid, o_lsu_resp_valid, o_mem_wen}), 64'd0);
        chk({tag, "_rdata"}, o_ifu_rdata | o_lsu_rdata, 64'd0);
        chk({tag, "_mem"}, o_mem_addr | o_mem_wdata | 64'(o_mem_wmask), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: IFU alone, single-cycle memory
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0000;
        #1;
        chk("t1_ifu_ready", 64'(o_ifu_req_ready), 64'd1);
        chk("t1_mem_idle", 64'(o_mem_req_valid), 64'd0);
        tick();
        i_ifu_req_valid = 1'b0;
        #1;
        chk("t1_mem_valid", 64'(o_mem_req_valid), 64'd1);
        chk("t1_mem_addr", o_mem_addr, 64'h8000_0000);
        chk("t1_mem_wr", 64'({o_mem_wen, o_mem_wmask}), 64'd0);
        i_mem_req_ready  = 1'b1;
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = 64'h13;
        tick();
        clear_inputs();
        #1;
        chk("t1_ifu_resp", 64'(o_ifu_resp_valid), 64'd1);
        chk("t1_ifu_rdata", o_ifu_rdata, 64'h13);
        chk("t1_lsu_resp", 64'(o_lsu_resp_valid), 64'd0);
        chk("t1_mem_done", 64'(o_mem_req_valid), 64'd0);
        tick();
        chk("t1_pulse_end", 64'(o_ifu_resp_valid), 64'd0);
        chk("t1_rdata_hold", o_ifu_rdata, 64'h13);

        // 2: ties alternate, LSU first after reset
        do_reset();
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0004;
        i_lsu_req_valid = 1'b1;
        i_lsu_addr      = 64'h8000_0200;
        #1;
        chk("t2_tie1_lsu", 64'(o_lsu_req_ready), 64'd1);
        chk("t2_tie1_ifu", 64'(o_ifu_req_ready), 64'd0);
        tick();
        i_lsu_req_valid = 1'b0;
        chk("t2_addr_b", o_mem_addr, 64'h8000_0200);
        chk("t2_ifu_busy", 64'(o_ifu_req_ready), 64'd0);
        serve(64'h55);
        i_lsu_req_valid = 1'b1;
        i_lsu_addr      = 64'h8000_0300;
        #1;
        chk("t2_lsu_resp", 64'(o_lsu_resp_valid), 64'd1);
        chk("t2_lsu_rdata", o_lsu_rdata, 64'h55);
        chk("t2_tie2_ifu", 64'(o_ifu_req_ready), 64'd1);
        chk("t2_tie2_lsu", 64'(o_lsu_req_ready), 64'd0);
        tick();
        i_ifu_req_valid = 1'b0;
        chk("t2_addr_a", o_mem_addr, 64'h8000_0004);
        serve(64'h77);
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0008;
        #1;
        chk("t2_ifu_rdata", o_ifu_rdata, 64'h77);
        chk("t2_tie3_lsu", 64'(o_lsu_req_ready), 64'd1);
        chk("t2_tie3_ifu", 64'(o_ifu_req_ready), 64'd0);
        tick();
        i_lsu_req_valid = 1'b0;
        chk("t2_addr_c", o_mem_addr, 64'h8000_0300);
        serve(64'h99);
        #1;
        chk("t2_lsu_rdata2", o_lsu_rdata, 64'h99);
        chk("t2_ifu_after", 64'(o_ifu_req_ready), 64'd1);
        tick();
        i_ifu_req_valid = 1'b0;
        serve(64'h0);
        tick();

        // 3: LSU store with memory stalling three cycles
        i_lsu_req_valid = 1'b1;
        i_lsu_wen       = 1'b1;
        i_lsu_addr      = 64'h8000_0100;
        i_lsu_wdata     = 64'hDEAD_BEEF;
        i_lsu_wmask     = 8'h0F;
        #1;
        chk("t3_lsu_ready", 64'(o_lsu_req_ready), 64'd1);
        tick();
        i_lsu_req_valid = 1'b0;
        i_lsu_wen       = 1'b0;
        i_lsu_addr      = '1;
        i_lsu_wdata     = '1;
        i_lsu_wmask     = '1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_valid", 64'(o_mem_req_valid), 64'd1);
            chk("t3_wen", 64'(o_mem_wen), 64'd1);
            chk("t3_addr", o_mem_addr, 64'h8000_0100);
            chk("t3_wdata", o_mem_wdata, 64'hDEAD_BEEF);
            chk("t3_wmask", 64'(o_mem_wmask), 64'h0F);
            tick();
        end
        serve(64'h1234);
        #1;
        chk("t3_lsu_resp", 64'(o_lsu_resp_valid), 64'd1);
        chk("t3_store_rdata", o_lsu_rdata, 64'd0);
        chk("t3_ifu_quiet", 64'(o_ifu_resp_valid), 64'd0);
        tick();

        // 4: split response, ready at 1, response at 4
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0010;
        tick();
        i_ifu_req_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        i_lsu_req_valid = 1'b1;
        i_lsu_addr      = 64'h8000_0400;
        #1;
        chk("t4_resp_c2_valid", 64'(o_mem_req_valid), 64'd0);
        chk("t4_resp_c2_lsu", 64'(o_lsu_req_ready), 64'd0);
        tick();
        chk("t4_resp_c3_valid", 64'(o_mem_req_valid), 64'd0);
        chk("t4_resp_c3_pulse", 64'(o_ifu_resp_valid), 64'd0);
        tick();
        chk("t4_resp_c4_lsu", 64'(o_lsu_req_ready), 64'd0);
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = 64'hABCD;
        tick();
        i_mem_resp_valid = 1'b0;
        i_mem_rdata      = '0;
        #1;
        chk("t4_ifu_resp", 64'(o_ifu_resp_valid), 64'd1);
        chk("t4_ifu_rdata", o_ifu_rdata, 64'hABCD);
        chk("t4_lsu_grant", 64'(o_lsu_req_ready), 64'd1);
        tick();
        i_lsu_req_valid = 1'b0;
        chk("t4_pulse_end", 64'(o_ifu_resp_valid), 64'd0);
        serve(64'h11);
        tick();

        // 5: reset while waiting in RESP, then a stale response
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0020;
        tick();
        i_ifu_req_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_reset");
        tick();
        tick();
        rst_n = 1'b1;
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = 64'hBAD;
        tick();
        i_mem_resp_valid = 1'b0;
        i_mem_rdata      = '0;
        tick();
        chk("t5_no_pulse", 64'({o_ifu_resp_valid, o_lsu_resp_valid}), 64'd0);
        chk("t5_rdata", o_ifu_rdata, 64'd0);
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0030;
        #1;
        chk("t5_ifu_ready", 64'(o_ifu_req_ready), 64'd1);
        tick();
        i_ifu_req_valid = 1'b0;
        chk("t5_addr", o_mem_addr, 64'h8000_0030);
        serve(64'h2222);
        #1;
        chk("t5_ifu_resp", 64'(o_ifu_resp_valid), 64'd1);
        chk("t5_ifu_rdata", o_ifu_rdata, 64'h2222);
        tick();

        // 6: spurious memory response while idle
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = 64'hFFFF;
        tick();
        i_mem_resp_valid = 1'b0;
        i_mem_rdata      = '0;
        #1;
        chk("t6_no_pulse", 64'({o_ifu_resp_valid, o_lsu_resp_valid}), 64'd0);
        chk("t6_ifu_rdata", o_ifu_rdata, 64'h2222);
        chk("t6_lsu_rdata", o_lsu_rdata, 64'd0);
        chk("t6_mem_idle", 64'(o_mem_req_valid), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
